// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, field slices.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;

  localparam logic [7:0] HLT_INSTR = 8'hFF;

  // Instruction byte field slices
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_OPND,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  // Opcodes that carry an operand word after the instruction byte
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op >= OP_ADDI) && (op <= OP_JZ);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Four-entry register file: two operand read ports, a debug read port, one write port.
module cpu_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        raddr_a_i,
  input  logic [1:0]        raddr_b_i,
  input  logic [1:0]        dbg_sel_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [3:0][DATA_W-1:0] regs_q;

  // Register storage, cleared by reset, single synchronous write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else if (we_i) regs_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle core: one shared req/ready memory port for fetch, operand and data.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              err,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_o,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic                z_q, z_d, err_q, err_d, retire_q, retire_d;
  logic                live_q;  // low for the first edge after reset so mem_req stays low in reset

  logic [7:0]          instr;
  logic [3:0]          instr_op, op;
  logic [1:0]          rd, rs;
  logic [ADDR_W-1:0]   tgt;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata, rd_val, rs_val;

  assign instr    = mem_rdata[7:0];
  assign instr_op = instr[OP_MSB:OP_LSB];
  assign op       = ir_q[OP_MSB:OP_LSB];
  assign rd       = ir_q[RD_MSB:RD_LSB];
  assign rs       = ir_q[RS_MSB:RS_LSB];
  assign tgt      = ADDR_W'(opnd_q);

  cpu_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rd),
    .raddr_b_i (rs),
    .dbg_sel_i (dbg_sel),
    .rdata_a_o (rd_val),
    .rdata_b_o (rs_val),
    .dbg_data_o(dbg_data)
  );

  // Architectural and control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      opnd_q   <= '0;
      z_q      <= 1'b0;
      err_q    <= 1'b0;
      retire_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opnd_q   <= opnd_d;
      z_q      <= z_d;
      err_q    <= err_d;
      retire_q <= retire_d;
      live_q   <= 1'b1;
    end
  end

  // Next-state, bus drive, ALU and register write
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opnd_d    = opnd_q;
    z_d       = z_q;
    err_d     = err_q;
    retire_d  = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = '0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = live_q;
        if (mem_req && mem_ready) begin
          ir_d = instr;
          pc_d = pc_q + ADDR_W'(1);
          if (instr == HLT_INSTR) begin
            state_d  = S_HALT;
            retire_d = 1'b1;
          end else if (instr_op > OP_JZ) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else if (is_two_byte(instr_op)) begin
            state_d = S_OPND;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_OPND: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          opnd_d  = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (op == OP_LD || op == OP_ST) ? S_MEM : S_EXEC;
        end
      end
      S_EXEC: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
        case (op)
          OP_ADD:  begin rf_we = 1'b1; rf_wdata = rd_val + rs_val; end
          OP_SUB:  begin rf_we = 1'b1; rf_wdata = rd_val - rs_val; end
          OP_MOV:  begin rf_we = 1'b1; rf_wdata = rs_val; end
          OP_ADDI: begin rf_we = 1'b1; rf_wdata = rd_val + opnd_q; end
          OP_JMP:  pc_d = tgt;
          OP_JZ:   if (z_q) pc_d = tgt;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = tgt;
        mem_we    = (op == OP_ST);
        mem_wdata = (op == OP_ST) ? rs_val : '0;
        if (mem_ready) begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
          if (op == OP_LD) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
    // Every written result except MOV updates Z
    if (rf_we && op != OP_MOV) z_d = (rf_wdata == '0);
  end

  assign halted = (state_q == S_HALT);
  assign err    = err_q;
  assign retire = retire_q;
  assign pc_o   = pc_q;

endmodule

// File: tb/tb_cpu_core_mc.sv
// Randomised bench for cpu_core_mc against an instruction-level reference interpreter.
module tb_cpu_core_mc;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 8-bit DUT bus
  logic       mem_req, mem_we, mem_ready, halted, err, retire;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_o, dbg_data;
  logic [1:0] dbg_sel = 2'd0;

  // 16-bit DUT bus
  logic        mem_req16, mem_we16, mem_ready16, halted16, err16, retire16;
  logic [7:0]  mem_addr16, pc16;
  logic [15:0] mem_wdata16, mem_rdata16, dbg_data16;
  logic [1:0]  dbg_sel16 = 2'd0;

  logic [7:0]  img [256];
  logic [7:0]  mem [256];
  logic [7:0]  exp_mem [256];
  logic [7:0]  exp_r [4];
  logic [7:0]  exp_pc;
  logic [15:0] m16 [256];
  bit          exp_err, exp_halt, load_req, rand_wait, stall, held;
  int          exp_ret, exp_cyc, ret_cnt, cyc, n_chk, n_pass;
  int unsigned wcnt;
  logic [16:0] h_bus;

  cpu_core_mc dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted),
    .err(err), .retire(retire), .pc_o(pc_o), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  cpu_core_mc #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
    .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16), .mem_ready(mem_ready16), .halted(halted16),
    .err(err16), .retire(retire16), .pc_o(pc16), .dbg_sel(dbg_sel16), .dbg_data(dbg_data16)
  );

  assign mem_rdata   = mem[mem_addr];
  assign mem_ready   = mem_req && !stall && (wcnt == 0);
  assign mem_rdata16 = m16[mem_addr16];
  assign mem_ready16 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory model with optional random wait states
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      wcnt <= 0;
    end else if (mem_ready) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      wcnt <= rand_wait ? $urandom_range(3, 0) : 0;
    end else if (mem_req && wcnt != 0) begin
      wcnt <= wcnt - 1;
    end
  end

  // Bus must hold still while a request waits for ready
  always @(posedge clk) begin
    if (rst_n && mem_req && held)
      chk("bus_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(h_bus));
    held  <= rst_n && mem_req && !mem_ready;
    h_bus <= {mem_we, mem_addr, mem_wdata};
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      ret_cnt <= 0;
      cyc     <= 0;
    end else begin
      if (retire) ret_cnt <= ret_cnt + 1;
      if (!halted) cyc <= cyc + 1;
    end
  end

  // Instruction-level interpreter: runs img until halt or max_ret retirements
  task automatic model_run(input int max_ret);
    logic [7:0] m [256];
    logic [7:0] r [4];
    logic [7:0] pc, ins, o;
    logic [3:0] op;
    logic [1:0] rd, rs;
    bit z;
    int steps;
    for (int i = 0; i < 256; i++) m[i] = img[i];
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    z = 0; pc = 0; steps = 0;
    exp_ret = 0; exp_cyc = 0; exp_err = 0; exp_halt = 0;
    while (!exp_halt && exp_ret < max_ret && steps < 4000) begin
      steps++;
      ins = m[pc]; pc = pc + 8'd1;
      if (ins == 8'hFF) begin
        exp_halt = 1; exp_ret++; exp_cyc += 1;
      end else if (ins[7:4] > 4'd7) begin
        exp_halt = 1; exp_err = 1; exp_cyc += 1;
      end else begin
        op = ins[7:4]; rd = ins[3:2]; rs = ins[1:0]; o = 8'h00;
        if (op >= 4'd3) begin o = m[pc]; pc = pc + 8'd1; exp_cyc += 3; end
        else exp_cyc += 2;
        case (op)
          4'd0: begin r[rd] = r[rd] + r[rs]; z = (r[rd] == 0); end
          4'd1: begin r[rd] = r[rd] - r[rs]; z = (r[rd] == 0); end
          4'd2: r[rd] = r[rs];
          4'd3: begin r[rd] = r[rd] + o; z = (r[rd] == 0); end
          4'd4: begin r[rd] = m[o]; z = (r[rd] == 0); end
          4'd5: m[o] = r[rs];
          4'd6: pc = o;
          default: if (z) pc = o;
        endcase
        exp_ret++;
      end
    end
    exp_pc = pc;
    for (int i = 0; i < 256; i++) exp_mem[i] = m[i];
    for (int i = 0; i < 4; i++) exp_r[i] = r[i];
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic start(input bit rw);
    rand_wait = rw; stall = 0;
    rst_n = 0; load_req = 1;
    repeat (2) @(posedge clk);
    load_req = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_halt"}, 32'(halted), 32'(exp_halt));
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_all(input string tag, input bit with_cyc);
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      chk($sformatf("%s_R%0d", tag, i), 32'(dbg_data), 32'(exp_r[i]));
    end
    chk({tag, "_pc"}, 32'(pc_o), 32'(exp_pc));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_retires"}, 32'(ret_cnt), 32'(exp_ret));
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk({tag, "_mem_diffs"}, 32'(bad), 32'd0);
    if (with_cyc) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc + 1));
  endtask

  initial begin
    int n, seen, p;
    logic [3:0] op;

    // 16-bit program: wrap to 1 with Z=0, then wrap to 0 with Z=1
    for (int i = 0; i < 256; i++) m16[i] = 16'h0000;
    m16[0] = 16'h0030; m16[1] = 16'hFFFF; m16[2] = 16'h0030; m16[3] = 16'h0002;
    m16[4] = 16'h0024; m16[5] = 16'h0070; m16[6] = 16'h000B; m16[7] = 16'h0030;
    m16[8] = 16'hFFFF; m16[9] = 16'h0070; m16[10] = 16'h000D; m16[11] = 16'h009C;
    m16[12] = 16'h009C; m16[13] = 16'h00FF;

    // Reset state
    #1 rst_n = 0;
    #6;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);

    // ADDI R0,5; ADDI R1,3; ADD R0,R1; HLT -- zero wait, then random waits
    clear_img();
    img[0] = 8'h30; img[1] = 8'h05; img[2] = 8'h34; img[3] = 8'h03; img[4] = 8'h01; img[5] = 8'hFF;
    model_run(1000);
    start(0); wait_halt("progA", 200); cmp_all("progA", 1);
    chk("progA_R0_const", 32'(exp_r[0]), 32'h08);
    for (int t = 0; t < 2; t++) begin
      start(1); wait_halt("progA_wait", 400); cmp_all($sformatf("progA_wait%0d", t), 0);
    end

    // ST/LD round trip, SUB to zero, JZ back to 0
    clear_img();
    img[0] = 8'h38; img[1] = 8'hAA; img[2] = 8'h52; img[3] = 8'h40; img[4] = 8'h4C;
    img[5] = 8'h40; img[6] = 8'h1E; img[7] = 8'h70; img[8] = 8'h00;
    model_run(5);
    start(0);
    n = 0; seen = 0;
    while (seen < 5 && n < 200) begin @(negedge clk); n++; if (retire) seen++; end
    chk("jz_retires", 32'(seen), 32'd5);
    chk("jz_pc", 32'(pc_o), 32'(exp_pc));
    chk("jz_m40", 32'(mem[8'h40]), 32'hAA);
    for (int i = 2; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      chk($sformatf("jz_R%0d", i), 32'(dbg_data), 32'(exp_r[i]));
    end

    // PC wrap: operand fetched from 0xFF, next fetch at 0x00
    clear_img();
    img[0] = 8'h00; img[1] = 8'h70; img[2] = 8'hFE; img[3] = 8'hFF; img[254] = 8'h30; img[255] = 8'h07;
    model_run(1000);
    start(0); wait_halt("wrap", 200); cmp_all("wrap", 1);

    // Illegal opcode halts with err, no retire, no further requests
    clear_img();
    img[0] = 8'h9C;
    model_run(1000);
    start(0); wait_halt("illegal", 50);
    n = 0;
    repeat (5) begin @(negedge clk); if (mem_req) n++; end
    chk("illegal_no_req", 32'(n), 32'd0);
    cmp_all("illegal", 1);

    // Random straight-line programs, alternating zero and random waits
    for (int t = 0; t < 6; t++) begin
      clear_img();
      for (int i = 128; i < 256; i++) img[i] = 8'($urandom);
      p = 0;
      while (p < 56) begin
        op = 4'($urandom_range(5, 0));
        img[p] = {op, 4'($urandom)}; p++;
        if (op >= 4'd3) begin
          img[p] = (op == 4'd3) ? 8'($urandom) : 8'($urandom_range(255, 128)); p++;
        end
      end
      img[p] = 8'hFF;
      model_run(1000);
      start(t[0]); wait_halt("rand", 2000); cmp_all($sformatf("rand%0d", t), !t[0]);
    end

    // Reset asserted mid data access
    clear_img();
    img[0] = 8'h30; img[1] = 8'h11; img[2] = 8'h44; img[3] = 8'h80; img[4] = 8'hFF; img[128] = 8'h55;
    model_run(1000);
    start(0);
    n = 0;
    while (!(mem_req && mem_addr == 8'h80) && n < 50) begin @(negedge clk); n++; end
    chk("rstmid_reach_mem", 32'(mem_req && mem_addr == 8'h80), 32'd1);
    stall = 1;
    @(posedge clk); #2;
    chk("rstmid_pre_req", 32'(mem_req), 32'd1);
    rst_n = 0; #1;
    chk("rstmid_req_async", 32'(mem_req), 32'd0);
    chk("rstmid_pc", 32'(pc_o), 32'd0);
    chk("rstmid_addr", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      chk($sformatf("rstmid_R%0d", i), 32'(dbg_data), 32'd0);
    end
    stall = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rstmid_refetch", 32'({mem_req, mem_addr}), 32'({1'b1, 8'h00}));
    wait_halt("rstmid", 200); cmp_all("rstmid", 1);

    // 16-bit instance has been running since the last reset release
    repeat (40) @(negedge clk);
    chk("w16_halt", 32'(halted16), 32'd1);
    chk("w16_err", 32'(err16), 32'd0);
    chk("w16_pc", 32'(pc16), 32'h0E);
    dbg_sel16 = 2'd0; #1;
    chk("w16_R0", 32'(dbg_data16), 32'h0000);
    dbg_sel16 = 2'd1; #1;
    chk("w16_R1", 32'(dbg_data16), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
Multi-cycle, parametrised successor to the single-cycle 8-bit core. It fetches instructions and operands over one shared memory port with a req/ready handshake, so memory wait states are tolerated. Data width and address width are parametrised. The core adds a zero flag, conditional and unconditional jumps, a sticky halt state with an error flag, and a debug register read port. It sits between the testbench or SoC memory model and the program image.

Parameters:
DATA_W, 8, register, ALU and memory word width (minimum 8)
ADDR_W, 8, memory address and PC width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data; sampled on the edge where mem_ready is high
mem_ready  in  1  transaction completes on the posedge where mem_req and mem_ready are both high
halted  out  1  core is in S_HALT
err  out  1  halt was caused by an illegal opcode
retire  out  1  one-cycle pulse per completed instruction
pc_o  out  ADDR_W  current PC
dbg_sel  in  2  debug register select
dbg_data  out  DATA_W  combinational read of R[dbg_sel]

Behaviour:
- Instruction byte = mem_rdata[7:0]. Fields: op = [7:4], rd = [3:2], rs = [1:0]. Four registers R0..R3.
- Opcodes:
  - 0 ADD: rd = rd + rs
  - 1 SUB: rd = rd - rs
  - 2 MOV: rd = rs
  - 3 ADDI imm: rd = rd + imm
  - 4 LD a: rd = M[a]
  - 5 ST a: M[a] = rs
  - 6 JMP a
  - 7 JZ a: jump if Z = 1
  - 8'hFF: HLT
  - Anything else is illegal.
- Opcodes 3-7 are two-byte: the operand word follows the instruction. a = operand[ADDR_W-1:0]; imm = full operand word.
- All arithmetic is modulo 2^DATA_W with no carry out.
- Z is set from the written result of ADD, SUB, ADDI and LD. MOV, ST and jumps leave Z unchanged.
- FSM states: S_FETCH, S_OPND, S_EXEC, S_MEM, S_HALT.
  - S_FETCH: req read at pc. On ready: latch IR; pc = pc + 1.
    - HLT goes to S_HALT.
    - An illegal opcode goes to S_HALT with err = 1.
    - Two-byte opcodes go to S_OPND.
    - Others go to S_EXEC.
  - S_OPND: req read at pc. On ready: latch OPND; pc = pc + 1. LD and ST go to S_MEM; others go to S_EXEC.
  - S_EXEC: one cycle, no memory request. Perform register write, Z update, or pc = a (JMP, and JZ when taken). Pulse retire. Go to S_FETCH.
  - S_MEM: req at a; mem_we = 1 for ST with wdata = R[rs]. On ready: LD writes R[rd] and Z. Pulse retire. Go to S_FETCH.
  - S_HALT: sticky until rst_n; mem_req = 0. Entering on HLT pulses retire once. Entering on an illegal opcode does not pulse retire.
- mem_req, mem_we, mem_addr and mem_wdata stay stable while waiting for ready. mem_req is driven combinationally from the state.
- With zero wait states:
  - one-byte ALU op = 2 cycles
  - ADDI, JMP, JZ = 3 cycles
  - LD, ST = 3 cycles
  - Each wait cycle on mem_ready adds 1 cycle.
- PC wraps from 2^ADDR_W-1 to 0. An operand fetched at the wrapped address is legal.
- A ST into the program area takes effect on the next fetch; there is no prefetch.
- Reset (async assert, any state, including mid-transaction):
  - state = S_FETCH, pc = RESET_PC, R0..R3 = 0, Z = 0
  - halted = 0, err = 0, retire = 0, mem_req = 0 immediately
  - mem_we = 0, mem_addr = RESET_PC, mem_wdata = 0
  - De-assertion is synchronised by the flop design; the first request occurs on the first edge after release.
- mem_ready while mem_req = 0 is ignored.

Decomposition:
- Package cpu_pkg:
  - opcode localparams OP_ADD..OP_JZ and HLT_INSTR = 8'hFF
  - state enum S_FETCH..S_HALT
  - field-slice constants
  - two-byte decode function is_two_byte(op)
- Sub-module cpu_regfile #(DATA_W): 4 entries, async-reset, 2 combinational read ports plus the debug read port, 1 synchronous write port.
- The ALU is inline in cpu_core_mc.

Test Plan:
- Zero-wait program `ADDI R0,5; ADDI R1,3; ADD R0,R1; HLT` -> R0 = 08, R1 = 03, halted after 9 cycles, retire pulsed 4 times, err = 0.
- Random 0-3 wait states on mem_ready, same program -> identical register results. Bus signals stay stable during waits; no double retire.
- `ADDI R2,AA; ST R2,40; LD R3,40; SUB R3,R2; JZ 00` -> M[40] = AA, R3 = 00, Z = 1, JZ taken, pc returns to 00.
- DATA_W = 16: `ADDI R0,FFFF; ADDI R0,0002` -> R0 = 0001, Z = 0. Then ADDI R0,FFFF -> R0 = 0000, Z = 1.
- Illegal byte 8'h9C at address 0 -> halted = 1, err = 1, no retire, mem_req stays 0 thereafter.
- Assert rst_n low during S_MEM with mem_req high -> mem_req falls without waiting for a clock. After release: pc = RESET_PC, registers 0, fetch resumes at RESET_PC.
